// File: rtl/alu_frame_serializer.sv
// Parallel operand/opcode to serial ALU frame converter with trailing CRC-4.
// Optional fault injection on in_err_mode when ALU_SER_ERR_INJECT_EN is defined.
module alu_frame_serializer #(
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_op,
`ifdef ALU_SER_ERR_INJECT_EN
    input  logic [1:0]        in_err_mode,
`endif
    output logic              sin,
    output logic              busy,
    output logic              done
);

    localparam int NB   = DATA_W / 8;
    localparam int NPKT = 2 * NB;
    localparam int CW   = $clog2(NPKT + 1);
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LEFT_INIT = CW'(NPKT - 1);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_GAP, S_CMD, S_DONE} state_e;

    function automatic logic [3:0] crc4(input logic [2*DATA_W+3:0] s);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 2*DATA_W+3; i >= 0; i--) begin
            fb = s[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [10:0]         pkt_q, pkt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]       left_q, left_d;
    logic [2*DATA_W-1:0] frm_q, frm_d;
    logic [2:0]          op_q, op_d;
    logic [3:0]          crc_q, crc_d;
    logic [1:0]          err_q, err_d;
    logic                adv;
    logic                omit;
    logic [10:0]         cmd_pkt;
    logic [10:0]         data_pkt;

    // Remaining bytes sit MSB-aligned in frm_q; each data load shifts one out.
    assign omit     = (err_q == 2'b10);
    assign data_pkt = {2'b00, frm_q[2*DATA_W-1 -: 8], 1'b1};
    assign cmd_pkt  = {1'b0, (err_q != 2'b11), 1'b0, op_q,
                       crc_q ^ {3'b000, (err_q == 2'b01)}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pkt_q     <= '1;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            left_q    <= '0;
            frm_q     <= '0;
            op_q      <= '0;
            crc_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            left_q    <= left_d;
            frm_q     <= frm_d;
            op_q      <= op_d;
            crc_q     <= crc_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        left_d    = left_q;
        frm_d     = frm_q;
        op_d      = op_q;
        crc_d     = crc_q;
        err_d     = err_q;
        adv       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_DATA;
                    pkt_d     = {2'b00, in_b[DATA_W-1 -: 8], 1'b1};
                    frm_d     = {in_b, in_a} << 8;
                    bit_cnt_d = '0;
                    left_d    = LEFT_INIT;
                    op_d      = in_op;
                    crc_d     = crc4({in_b, in_a, 1'b1, in_op});
`ifdef ALU_SER_ERR_INJECT_EN
                    err_d     = in_err_mode;
`else
                    err_d     = 2'b00;
`endif
                end
            end
            S_DATA, S_CMD: begin
                pkt_d     = {pkt_q[9:0], 1'b1};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd10) begin
                    if (state_q == S_CMD) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) adv = 1'b1;
                else gap_cnt_d = gap_cnt_q + GW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An omitted packet keeps its trailing gap so frame timing stays regular.
        if (adv) begin
            bit_cnt_d = '0;
            if (left_q != '0 && !(omit && left_q == CW'(1))) begin
                state_d = S_DATA;
                pkt_d   = data_pkt;
                frm_d   = {frm_q[2*DATA_W-9:0], 8'h00};
                left_d  = left_q - CW'(1);
            end else if (left_q != '0 && GAP_CYCLES > 0) begin
                left_d    = '0;
                state_d   = S_GAP;
                gap_cnt_d = '0;
            end else begin
                left_d  = '0;
                state_d = S_CMD;
                pkt_d   = cmd_pkt;
            end
        end
    end

    always_comb begin
        sin      = 1'b1;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_DATA, S_CMD: begin
                sin  = pkt_q[10];
                busy = 1'b1;
            end
            S_GAP:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_frame_serializer.sv
// Scoreboard bench for alu_frame_serializer: default gap instance plus a
// zero-gap instance for back-to-back frames.
module tb_alu_frame_serializer;

    typedef struct packed {
        logic s;
        logic b;
        logic d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [1:0]  in_err_mode = '0;
    logic        in_ready, sin, busy, done;

    logic        v0 = 1'b0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic [2:0]  op0 = '0;
    logic [1:0]  err0 = '0;
    logic        ready0, sin0, busy0, done0;

    exp_t sb_q[$];
    exp_t sb0_q[$];
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_frame_serializer dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_op(in_op),
`ifdef ALU_SER_ERR_INJECT_EN
        .in_err_mode(in_err_mode),
`endif
        .sin(sin),
        .busy(busy),
        .done(done)
    );

    alu_frame_serializer #(.DATA_W(32), .GAP_CYCLES(0)) dut0 (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(v0),
        .in_ready(ready0),
        .in_a(a0),
        .in_b(b0),
        .in_op(op0),
`ifdef ALU_SER_ERR_INJECT_EN
        .in_err_mode(err0),
`endif
        .sin(sin0),
        .busy(busy0),
        .done(done0)
    );

    function automatic logic [3:0] ref_crc(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0] op);
        logic [67:0] s;
        logic [3:0]  r;
        s = {b, a, 1'b1, op};
        r = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            if (s[i] ^ r[3]) r = {r[2:0], 1'b0} ^ 4'b0011;
            else r = {r[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic void push(input bit which, input exp_t e);
        if (which) sb0_q.push_back(e);
        else sb_q.push_back(e);
    endfunction

    function automatic exp_t obs(input bit which);
        if (which) return exp_t'({sin0, busy0, done0});
        return exp_t'({sin, busy, done});
    endfunction

    task automatic push_frame(input bit which, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] op,
                              input logic [1:0] mode, input int gap);
        logic [7:0]  byt;
        logic [10:0] pk;
        logic [3:0]  c;
        for (int p = 0; p < 8; p++) begin
            byt = (p < 4) ? b[31-8*p -: 8] : a[31-8*(p-4) -: 8];
            if (!(mode == 2'b10 && p == 7)) begin
                pk = {2'b00, byt, 1'b1};
                for (int k = 10; k >= 0; k--) push(which, exp_t'({pk[k], 2'b10}));
            end
            for (int g = 0; g < gap; g++) push(which, exp_t'(3'b110));
        end
        c = ref_crc(a, b, op);
        if (mode == 2'b01) c[0] = ~c[0];
        pk = {1'b0, (mode != 2'b11), 1'b0, op, c, 1'b1};
        for (int k = 10; k >= 0; k--) push(which, exp_t'({pk[k], 2'b10}));
        push(which, exp_t'(3'b101));
    endtask

    task automatic drain(input bit which, input int n, input string tag);
        exp_t e, o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_run++;
            if ((which ? sb0_q.size() : sb_q.size()) == 0) begin
                n_fail++;
                $display("FAIL %s step %0d: scoreboard empty", tag, i);
            end else begin
                e = which ? sb0_q.pop_front() : sb_q.pop_front();
                o = obs(which);
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s step %0d: sin/busy/done got %b want %b",
                             tag, i + 1, o, e);
                end
            end
        end
    endtask

    task automatic drain_all(input bit which, input string tag);
        drain(which, which ? sb0_q.size() : sb_q.size(), tag);
    endtask

    task automatic check_ready(input string tag);
        @(negedge clk);
        n_run++;
        if ({in_ready, sin, busy, done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s ready/sin/busy/done got %b want 1100",
                     tag, {in_ready, sin, busy, done});
        end
    endtask

    task automatic start_frame(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic [1:0] mode);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_run++;
            n_fail++;
            $display("FAIL accept_timeout in_ready got 0 want 1");
        end
        in_a = a;
        in_b = b;
        in_op = op;
        in_err_mode = mode;
        in_valid = 1'b1;
        push_frame(1'b0, a, b, op, mode, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_op = 3'($urandom);
        in_err_mode = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) check_ready("reset_idle");
    endtask

    task automatic test_zero_frame();
        start_frame(32'h0, 32'h0, 3'b000, 2'b00);
        drain_all(1'b0, "zero_frame");
        check_ready("zero_ready");
    endtask

    task automatic test_pattern();
        start_frame(32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 2'b00);
        drain_all(1'b0, "pattern");
        check_ready("pattern_ready");
    endtask

    task automatic test_ops();
        logic [2:0] ops [4];
        ops = '{3'b010, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 4; i++) begin
            start_frame($urandom, $urandom, ops[i], 2'b00);
            drain_all(1'b0, "undef_op");
        end
        check_ready("ops_ready");
    endtask

    task automatic test_mid_reset();
        start_frame(32'hA5A5_1234, 32'h5A5A_8765, 3'b001, 2'b00);
        drain(1'b0, 39, "pre_reset");
        rst_n = 1'b0;
        @(negedge clk);
        n_run++;
        if ({in_ready, sin, busy, done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL mid_reset ready/sin/busy/done got %b want 1100",
                     {in_ready, sin, busy, done});
        end
        rst_n = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 3; i++) check_ready("post_reset");
        start_frame(32'h0BAD_F00D, 32'hC0FF_EE00, 3'b100, 2'b00);
        drain_all(1'b0, "after_reset");
        check_ready("after_reset_ready");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a2, b2;
        @(negedge clk);
        v0 = 1'b1;
        a0 = 32'h1357_9BDF;
        b0 = 32'h2468_ACE0;
        op0 = 3'b110;
        push_frame(1'b1, a0, b0, op0, 2'b00, 0);
        @(posedge clk);
        #1;
        drain(1'b1, 50, "b2b_first");
        a0 = 32'hDEAD_BEEF;
        b0 = 32'hFEED_FACE;
        op0 = 3'b011;
        drain(1'b1, 50, "b2b_first");
        a2 = 32'h8000_0001;
        b2 = 32'h7F00_00FE;
        a0 = a2;
        b0 = b2;
        op0 = 3'b111;
        push_frame(1'b1, a2, b2, 3'b111, 2'b00, 0);
        @(negedge clk);
        n_run++;
        if ({ready0, sin0, busy0, done0} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_reaccept ready/sin/busy/done got %b want 1100",
                     {ready0, sin0, busy0, done0});
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        a0 = $urandom;
        b0 = $urandom;
        drain_all(1'b1, "b2b_second");
        @(negedge clk);
        n_run++;
        if ({ready0, sin0, busy0, done0} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_ready ready/sin/busy/done got %b want 1100",
                     {ready0, sin0, busy0, done0});
        end
    endtask

`ifdef ALU_SER_ERR_INJECT_EN
    task automatic test_err_inject();
        start_frame(32'h0, 32'h0, 3'b000, 2'b01);
        drain_all(1'b0, "err_crc");
        start_frame(32'h1122_3344, 32'h5566_7788, 3'b010, 2'b10);
        drain_all(1'b0, "err_omit");
        start_frame(32'h9999_0000, 32'h0000_9999, 3'b101, 2'b11);
        drain_all(1'b0, "err_type");
        check_ready("err_ready");
    endtask
`endif

    initial begin
        test_reset();
        test_zero_frame();
        test_pattern();
        test_ops();
        test_mid_reset();
        test_back_to_back();
`ifdef ALU_SER_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
